// File: rtl/obi_to_apb_xbar_bridge.sv
`default_nettype none
// ============================================================================
// Module   : obi_to_apb_xbar_bridge
// Brief    : OBI subordinate to N-port APB4 manager, region-decoded, with
//            decode-miss errors and a PREADY timeout abort.
// Revision : 1.0  initial release
// ============================================================================
module obi_to_apb_xbar_bridge #(
  parameter int                       ADDR_W   = 32,
  parameter int                       DATA_W   = 32,
  parameter int                       N_SUB    = 4,
  parameter logic [N_SUB*ADDR_W-1:0]  SUB_BASE = '0,
  parameter logic [N_SUB*ADDR_W-1:0]  SUB_MASK = '0,
  parameter int                       TIMEOUT  = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      obi_req_i,
  output logic                      obi_gnt_o,
  input  logic [ADDR_W-1:0]         obi_addr_i,
  input  logic                      obi_we_i,
  input  logic [DATA_W/8-1:0]       obi_be_i,
  input  logic [DATA_W-1:0]         obi_wdata_i,
  output logic                      obi_rvalid_o,
  output logic [DATA_W-1:0]         obi_rdata_o,
  output logic                      obi_err_o,
  output logic [ADDR_W-1:0]         apb_paddr_o,
  output logic [N_SUB-1:0]          apb_psel_o,
  output logic                      apb_penable_o,
  output logic                      apb_pwrite_o,
  output logic [DATA_W-1:0]         apb_pwdata_o,
  output logic [DATA_W/8-1:0]       apb_pstrb_o,
  output logic [2:0]                apb_pprot_o,
  input  logic [N_SUB*DATA_W-1:0]   apb_prdata_i,
  input  logic [N_SUB-1:0]          apb_pready_i,
  input  logic [N_SUB-1:0]          apb_pslverr_i,
  output logic                      timeout_o
);

  localparam int                c_BE_W    = DATA_W / 8;
  localparam int                c_SEL_W   = (N_SUB > 1) ? $clog2(N_SUB) : 1;
  localparam int                c_CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit                c_TO_EN   = (TIMEOUT != 0);
  localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT - 1);
  localparam logic [2:0]        c_PPROT   = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t               r_state;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_we;
  logic [c_BE_W-1:0]    r_be;
  logic [DATA_W-1:0]    r_wdata;
  logic [c_SEL_W-1:0]   r_sel;
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_err;
  logic                 r_timeout;
  logic [c_CNT_W-1:0]   r_cnt;

  logic                 w_accept;
  logic                 w_dec_hit;
  logic [c_SEL_W-1:0]   w_dec_idx;
  logic                 w_apb_active;
  logic                 w_pready;
  logic                 w_pslverr;
  logic [DATA_W-1:0]    w_prdata;

  // Scanning downward lets the lowest matching region overwrite higher ones.
  always_comb begin
    w_dec_hit = 1'b0;
    w_dec_idx = '0;
    for (int i = N_SUB - 1; i >= 0; i--) begin
      if ((obi_addr_i & SUB_MASK[i*ADDR_W +: ADDR_W]) == SUB_BASE[i*ADDR_W +: ADDR_W]) begin
        w_dec_hit = 1'b1;
        w_dec_idx = c_SEL_W'(i);
      end
    end
  end

  assign obi_gnt_o    = obi_req_i && !rst_i && ((r_state == S_IDLE) || (r_state == S_RESP));
  assign w_accept     = obi_gnt_o;
  assign w_apb_active = (r_state == S_SETUP) || (r_state == S_ACCESS);

  assign w_pready  = apb_pready_i[r_sel];
  assign w_pslverr = apb_pslverr_i[r_sel];
  assign w_prdata  = apb_prdata_i[r_sel*DATA_W +: DATA_W];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_sel     <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_accept) begin
            r_addr  <= obi_addr_i;
            r_we    <= obi_we_i;
            r_be    <= obi_be_i;
            r_wdata <= obi_wdata_i;
            r_sel   <= w_dec_idx;
            if (w_dec_hit) begin
              r_state <= S_SETUP;
            end else begin
              r_state <= S_RESP;
              r_err   <= 1'b1;
              r_rdata <= '0;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SETUP: begin
          r_cnt   <= '0;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_pready) begin
            r_rdata <= r_we ? '0 : w_prdata;
            r_err   <= w_pslverr;
            r_cnt   <= '0;
            r_state <= S_RESP;
          end else if (c_TO_EN && (r_cnt == c_TO_LAST)) begin
            r_rdata   <= '0;
            r_err     <= 1'b1;
            r_timeout <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_RESP;
          end else if (c_TO_EN) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  generate
    for (genvar g = 0; g < N_SUB; g++) begin : g_psel
      assign apb_psel_o[g] = w_apb_active && (r_sel == c_SEL_W'(g));
    end
  endgenerate

  assign apb_penable_o = (r_state == S_ACCESS);
  assign apb_paddr_o   = r_addr;
  assign apb_pwrite_o  = r_we;
  assign apb_pwdata_o  = r_wdata;
  assign apb_pstrb_o   = r_we ? r_be : '0;
  assign apb_pprot_o   = c_PPROT;

  assign obi_rvalid_o  = (r_state == S_RESP);
  assign obi_rdata_o   = r_rdata;
  assign obi_err_o     = r_err;
  assign timeout_o     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_obi_to_apb_xbar_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_obi_to_apb_xbar_bridge
// Brief    : Directed self-checking bench for the OBI-to-APB crossbar bridge.
// Revision : 1.0  initial release
// ============================================================================
module tb_obi_to_apb_xbar_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         req, we;
  logic [31:0]  addr, wdata;
  logic [3:0]   be;
  logic         gnt, rvalid, err, penable, pwrite, tmo;
  logic [31:0]  rdata, paddr, pwdata;
  logic [3:0]   psel, pstrb;
  logic [2:0]   pprot;
  logic [127:0] prdata;
  logic [3:0]   pready, pslverr;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  obi_to_apb_xbar_bridge #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .N_SUB    (4),
    .SUB_BASE ({32'h3000, 32'h2000, 32'h1000, 32'h0000}),
    .SUB_MASK ({4{32'hF000}}),
    .TIMEOUT  (8)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .obi_req_i     (req),
    .obi_gnt_o     (gnt),
    .obi_addr_i    (addr),
    .obi_we_i      (we),
    .obi_be_i      (be),
    .obi_wdata_i   (wdata),
    .obi_rvalid_o  (rvalid),
    .obi_rdata_o   (rdata),
    .obi_err_o     (err),
    .apb_paddr_o   (paddr),
    .apb_psel_o    (psel),
    .apb_penable_o (penable),
    .apb_pwrite_o  (pwrite),
    .apb_pwdata_o  (pwdata),
    .apb_pstrb_o   (pstrb),
    .apb_pprot_o   (pprot),
    .apb_prdata_i  (prdata),
    .apb_pready_i  (pready),
    .apb_pslverr_i (pslverr),
    .timeout_o     (tmo)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
    req = 1'b1; addr = a; we = w; be = b; wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if ({gnt, rvalid, err, psel, penable, pwrite, pstrb, tmo} !== 13'b0) begin
      n_mis++; $display("FAIL reset_ctl: got %b want 0", {gnt, rvalid, err, psel, penable, pwrite, pstrb, tmo});
    end
    n_cmp++;
    if ({rdata, paddr, pwdata} !== 96'h0) begin
      n_mis++; $display("FAIL reset_data: got %h want 0", {rdata, paddr, pwdata});
    end
    n_cmp++;
    if (pprot !== 3'b010) begin
      n_mis++; $display("FAIL reset_pprot: got %b want 010", pprot);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_read_hit();
    pready = 4'b0100; pslverr = 4'b0; prdata[64 +: 32] = 32'hDEADBEEF;
    issue(32'h2004, 1'b0, 4'hF, 32'h0);
    #1;
    n_cmp++;
    if (gnt !== 1'b1) begin n_mis++; $display("FAIL t1_gnt: got %b want 1", gnt); end
    step(); req = 1'b0;
    n_cmp++;
    if ({psel, penable, rvalid} !== 6'b0100_0_0) begin
      n_mis++; $display("FAIL t1_setup: got %b want 010000", {psel, penable, rvalid});
    end
    n_cmp++;
    if ({paddr, pstrb, pwrite} !== {32'h2004, 4'b0, 1'b0}) begin
      n_mis++; $display("FAIL t1_setup_bus: got %h want %h", {paddr, pstrb, pwrite}, {32'h2004, 4'b0, 1'b0});
    end
    step();
    n_cmp++;
    if ({psel, penable, rvalid} !== 6'b0100_1_0) begin
      n_mis++; $display("FAIL t1_access: got %b want 010010", {psel, penable, rvalid});
    end
    step();
    n_cmp++;
    if ({rvalid, err, psel, penable, rdata} !== {1'b1, 1'b0, 4'b0, 1'b0, 32'hDEADBEEF}) begin
      n_mis++; $display("FAIL t1_resp: got %h want %h", {rvalid, err, psel, penable, rdata}, {1'b1, 1'b0, 4'b0, 1'b0, 32'hDEADBEEF});
    end
    step();
    n_cmp++;
    if (rvalid !== 1'b0) begin n_mis++; $display("FAIL t1_single_pulse: got %b want 0", rvalid); end
  endtask

  task automatic test_write_wait();
    pready = 4'b0;
    issue(32'h2010, 1'b1, 4'b0011, 32'h1234);
    #1;
    n_cmp++;
    if (gnt !== 1'b1) begin n_mis++; $display("FAIL t2_gnt: got %b want 1", gnt); end
    step(); req = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) step();
      n_cmp++;
      if ({psel, pwrite, pstrb, pwdata, paddr, rvalid, penable} !==
          {4'b0100, 1'b1, 4'b0011, 32'h1234, 32'h2010, 1'b0, (k >= 2)}) begin
        n_mis++; $display("FAIL t2_hold_c%0d: got %h want %h", k,
          {psel, pwrite, pstrb, pwdata, paddr, rvalid, penable},
          {4'b0100, 1'b1, 4'b0011, 32'h1234, 32'h2010, 1'b0, (k >= 2)});
      end
      if (k == 5) pready = 4'b0100;
    end
    step();
    pready = 4'b0;
    n_cmp++;
    if ({rvalid, err, rdata} !== {1'b1, 1'b0, 32'h0}) begin
      n_mis++; $display("FAIL t2_resp: got %h want %h", {rvalid, err, rdata}, {1'b1, 1'b0, 32'h0});
    end
    step();
  endtask

  task automatic test_miss();
    prdata = {4{32'hFFFF_FFFF}}; pready = 4'b1111;
    issue(32'h9000, 1'b0, 4'hF, 32'h0);
    #1;
    n_cmp++;
    if (gnt !== 1'b1) begin n_mis++; $display("FAIL t3_gnt: got %b want 1", gnt); end
    step(); req = 1'b0;
    n_cmp++;
    if ({rvalid, err, psel, penable, rdata} !== {1'b1, 1'b1, 4'b0, 1'b0, 32'h0}) begin
      n_mis++; $display("FAIL t3_resp: got %h want %h", {rvalid, err, psel, penable, rdata}, {1'b1, 1'b1, 4'b0, 1'b0, 32'h0});
    end
    step();
    n_cmp++;
    if ({rvalid, psel} !== 5'b0) begin n_mis++; $display("FAIL t3_after: got %b want 0", {rvalid, psel}); end
    pready = 4'b0;
  endtask

  task automatic test_timeout();
    pready = 4'b0;
    issue(32'h3000, 1'b0, 4'hF, 32'h0);
    step(); req = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) step();
      n_cmp++;
      if ({rvalid, tmo, psel, penable} !== {1'b0, 1'b0, 4'b1000, (k >= 2)}) begin
        n_mis++; $display("FAIL t4_wait_c%0d: got %b want %b", k, {rvalid, tmo, psel, penable}, {1'b0, 1'b0, 4'b1000, (k >= 2)});
      end
    end
    step();
    n_cmp++;
    if ({rvalid, err, tmo, psel, penable, rdata} !== {1'b1, 1'b1, 1'b1, 4'b0, 1'b0, 32'h0}) begin
      n_mis++; $display("FAIL t4_abort: got %h want %h", {rvalid, err, tmo, psel, penable, rdata}, {1'b1, 1'b1, 1'b1, 4'b0, 1'b0, 32'h0});
    end
    pready = 4'b1000;
    step();
    n_cmp++;
    if ({rvalid, tmo, psel, penable} !== 7'b0) begin
      n_mis++; $display("FAIL t4_late_c11: got %b want 0", {rvalid, tmo, psel, penable});
    end
    step();
    n_cmp++;
    if ({rvalid, tmo} !== 2'b0) begin n_mis++; $display("FAIL t4_late_c12: got %b want 0", {rvalid, tmo}); end
    pready = 4'b0;
  endtask

  task automatic test_back_to_back();
    pready = 4'b0011; pslverr = 4'b0010; prdata = '0; prdata[0 +: 32] = 32'h1111_1111;
    issue(32'h0010, 1'b0, 4'hF, 32'h0);
    #1;
    n_cmp++;
    if (gnt !== 1'b1) begin n_mis++; $display("FAIL t5_gnt0: got %b want 1", gnt); end
    step();
    issue(32'h1020, 1'b1, 4'hF, 32'hA5A5_A5A5);
    #1;
    n_cmp++;
    if ({gnt, psel, penable} !== 6'b0_0001_0) begin
      n_mis++; $display("FAIL t5_setup: got %b want 000010", {gnt, psel, penable});
    end
    step();
    n_cmp++;
    if ({gnt, psel, penable} !== 6'b0_0001_1) begin
      n_mis++; $display("FAIL t5_access: got %b want 000011", {gnt, psel, penable});
    end
    step();
    n_cmp++;
    if ({gnt, rvalid, err, rdata} !== {1'b1, 1'b1, 1'b0, 32'h1111_1111}) begin
      n_mis++; $display("FAIL t5_resp0: got %h want %h", {gnt, rvalid, err, rdata}, {1'b1, 1'b1, 1'b0, 32'h1111_1111});
    end
    step(); req = 1'b0;
    n_cmp++;
    if ({psel, penable, pwrite, rvalid, paddr, pwdata} !== {4'b0010, 1'b0, 1'b1, 1'b0, 32'h1020, 32'hA5A5_A5A5}) begin
      n_mis++; $display("FAIL t5_setup1: got %h want %h", {psel, penable, pwrite, rvalid, paddr, pwdata},
        {4'b0010, 1'b0, 1'b1, 1'b0, 32'h1020, 32'hA5A5_A5A5});
    end
    step();
    n_cmp++;
    if ({psel, penable} !== 5'b0010_1) begin n_mis++; $display("FAIL t5_access1: got %b want 00101", {psel, penable}); end
    step();
    n_cmp++;
    if ({rvalid, err, rdata} !== {1'b1, 1'b1, 32'h0}) begin
      n_mis++; $display("FAIL t5_resp1: got %h want %h", {rvalid, err, rdata}, {1'b1, 1'b1, 32'h0});
    end
    pready = 4'b0; pslverr = 4'b0;
    step();
  endtask

  task automatic test_reset_during_access();
    pready = 4'b0;
    issue(32'h2008, 1'b0, 4'hF, 32'h0);
    step(); req = 1'b0;
    step();
    n_cmp++;
    if ({psel, penable} !== 5'b0100_1) begin n_mis++; $display("FAIL t6_pre: got %b want 01001", {psel, penable}); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({psel, penable, rvalid} !== 6'b0) begin
      n_mis++; $display("FAIL t6_abandon: got %b want 0", {psel, penable, rvalid});
    end
    step();
    n_cmp++;
    if ({psel, rvalid} !== 5'b0) begin n_mis++; $display("FAIL t6_no_resp: got %b want 0", {psel, rvalid}); end
    pready = 4'b0100; prdata[64 +: 32] = 32'hCAFE_F00D;
    issue(32'h2008, 1'b0, 4'hF, 32'h0);
    step(); req = 1'b0;
    step();
    step();
    n_cmp++;
    if ({rvalid, err, rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
      n_mis++; $display("FAIL t6_fresh: got %h want %h", {rvalid, err, rdata}, {1'b1, 1'b0, 32'hCAFE_F00D});
    end
    step();
    pready = 4'b0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    prdata = '0; pready = '0; pslverr = '0;
    test_reset();
    test_read_hit();
    test_write_wait();
    test_miss();
    test_timeout();
    test_back_to_back();
    test_reset_during_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
